// File: rtl/opl_write_sequencer.sv
// Register-write FIFO and host-bus sequencer for one or more OPL cores.
// Each queued (chip, reg, val) entry is replayed as an address strobe and then a data strobe, with recovery gaps after each.
module opl_write_sequencer #(
  parameter int DEPTH     = 512,
  parameter int NUM_CHIPS = 2,
  parameter int WR_PULSE  = 2,
  parameter int ADDR_GAP  = 30,
  parameter int DATA_GAP  = 200,
  localparam int CW = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                 phi2,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [CW-1:0]        push_chip,
  input  logic [7:0]           push_reg,
  input  logic [7:0]           push_val,
  input  logic                 flush,
  input  logic                 enable,
  output logic [NUM_CHIPS-1:0] h_wr_n,
  output logic                 h_a0,
  output logic [7:0]           h_din,
  output logic [LW-1:0]        level,
  output logic                 busy,
  output logic                 overflow
);

  typedef enum logic [2:0] {IDLE, ADDR, AGAP, DATA, DGAP} state_t;

  state_t              state;
  logic [15:0]         tc;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW+15:0]      mem [DEPTH];
  logic [CW+15:0]      head;
  logic [CW-1:0]       cur_chip;
  logic [7:0]          cur_reg, cur_val;
  logic                push_ok, pop, to_idle;
  logic [LW-1:0]       level_nxt;
  logic [NUM_CHIPS-1:0] strobe_mask;

  always_ff @(posedge phi2) begin
    if (push_ok) mem[wr_ptr] <= {push_chip, push_reg, push_val};
  end

  assign head = mem[rd_ptr];

  always_comb begin
    push_ok   = push && !flush && (level < LW'(DEPTH));
    pop       = !flush && (state == IDLE) && enable && (level != '0);
    level_nxt = level + LW'(push_ok) - LW'(pop);
    to_idle   = ((state == IDLE) && !pop) || ((state == DGAP) && (tc == '0));
    // Out-of-range chip indices match no bit, so the write runs with every strobe high.
    strobe_mask = '0;
    for (int unsigned i = 0; i < NUM_CHIPS; i++) begin
      strobe_mask[i] = (cur_chip == CW'(i));
    end
  end

  always_ff @(posedge phi2) begin
    if (!rst_n) begin
      state    <= IDLE;
      tc       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      h_wr_n   <= '1;
      h_a0     <= 1'b0;
      h_din    <= '0;
      cur_chip <= '0;
      cur_reg  <= '0;
      cur_val  <= '0;
    end else if (flush) begin
      state    <= IDLE;
      tc       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      h_wr_n   <= '1;
    end else begin
      level <= level_nxt;
      busy  <= (level_nxt != '0) || !to_idle;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (push && !push_ok) overflow <= 1'b1;
      // Strobes lag the state by one edge, while a0/din change on entry to ADDR/DATA,
      // so the bus is set up a full cycle before each falling strobe.
      h_wr_n <= ((state == ADDR) || (state == DATA)) ? ~strobe_mask : '1;
      case (state)
        IDLE: if (pop) begin
          {cur_chip, cur_reg, cur_val} <= head;
          rd_ptr <= rd_ptr + AW'(1);
          tc     <= 16'(WR_PULSE - 1);
          h_a0   <= 1'b0;
          h_din  <= head[15:8];
          state  <= ADDR;
        end
        ADDR: if (tc == '0) begin
          tc    <= 16'(ADDR_GAP - 1);
          state <= AGAP;
        end else tc <= tc - 16'd1;
        AGAP: if (tc == '0) begin
          tc    <= 16'(WR_PULSE - 1);
          h_a0  <= 1'b1;
          h_din <= cur_val;
          state <= DATA;
        end else tc <= tc - 16'd1;
        DATA: if (tc == '0) begin
          tc    <= 16'(DATA_GAP - 1);
          state <= DGAP;
        end else tc <= tc - 16'd1;
        DGAP: if (tc == '0) state <= IDLE;
              else tc <= tc - 16'd1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opl_write_sequencer.sv
// Bench for opl_write_sequencer: queue/timeline reference model compared every cycle, plus directed literal checks.
module tb_opl_write_sequencer;
  localparam int DEPTH = 4;
  localparam int NC    = 3;
  localparam int WP    = 2;
  localparam int AG    = 30;
  localparam int DG    = 200;
  localparam int TOTAL = 1 + 2*WP + AG + DG;

  logic          phi2, rst_n, push, flush, enable;
  logic [1:0]    push_chip;
  logic [7:0]    push_reg, push_val;
  logic [NC-1:0] h_wr_n;
  logic          h_a0, busy, overflow;
  logic [7:0]    h_din;
  logic [2:0]    level;

  opl_write_sequencer #(.DEPTH(DEPTH), .NUM_CHIPS(NC), .WR_PULSE(WP),
                        .ADDR_GAP(AG), .DATA_GAP(DG)) dut (
    .phi2(phi2), .rst_n(rst_n), .push(push), .push_chip(push_chip),
    .push_reg(push_reg), .push_val(push_val), .flush(flush), .enable(enable),
    .h_wr_n(h_wr_n), .h_a0(h_a0), .h_din(h_din), .level(level),
    .busy(busy), .overflow(overflow));

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: queue of entries plus the offset k of the write in flight since its load edge.
  logic [17:0]   q[$];
  logic [17:0]   cur;
  bit            active, model_ok;
  int            k, pre;
  logic [NC-1:0] m_wr_n;
  logic          m_a0, m_busy, m_ovf;
  logic [7:0]    m_din;
  int            m_level;

  initial begin
    model_ok = 0;
    forever begin
      @(posedge phi2);
      if (!rst_n) begin
        q.delete(); active = 0; k = 0; m_wr_n = '1; m_a0 = 0; m_din = 0;
        m_level = 0; m_busy = 0; m_ovf = 0; model_ok = 1;
      end else if (flush) begin
        q.delete(); active = 0; m_wr_n = '1; m_level = 0; m_busy = 0; m_ovf = 0;
      end else begin
        pre = q.size();
        if (active) begin
          k++;
          if (k == TOTAL - 1) active = 0;
          if (k == WP + AG) begin m_a0 = 1; m_din = cur[7:0]; end
        end else if (enable && pre != 0) begin
          cur = q.pop_front(); active = 1; k = 0; m_a0 = 0; m_din = cur[15:8];
        end
        if (push) begin
          if (pre < DEPTH) q.push_back({push_chip, push_reg, push_val});
          else m_ovf = 1;
        end
        m_wr_n = '1;
        if (active && ((k >= 1 && k <= WP) || (k >= WP + AG + 1 && k <= 2*WP + AG))
            && cur[17:16] < NC)
          m_wr_n[cur[17:16]] = 1'b0;
        m_level = q.size();
        m_busy  = active || (q.size() != 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge phi2);
      if (model_ok && rst_n) begin
        check("model_wr_n", 32'(h_wr_n), 32'(m_wr_n));
        check("model_a0", 32'(h_a0), 32'(m_a0));
        check("model_din", 32'(h_din), 32'(m_din));
        check("model_level", 32'(level), 32'(m_level));
        check("model_busy", 32'(busy), 32'(m_busy));
        check("model_overflow", 32'(overflow), 32'(m_ovf));
      end
    end
  end

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin @(negedge phi2); n++; end
    check("idle_timeout", 32'(busy), 32'(0));
  endtask

  task automatic wait_low(input int chip, input int limit, input string name);
    int n = 0;
    while (h_wr_n[chip] !== 1'b0 && n < limit) begin @(negedge phi2); n++; end
    check(name, 32'(h_wr_n[chip]), 32'(0));
  endtask

  task automatic do_push(input logic [1:0] c, input logic [7:0] r, input logic [7:0] v);
    push = 1; push_chip = c; push_reg = r; push_val = v;
    @(negedge phi2);
    push = 0;
  endtask

  logic [NC-1:0] w_hist [0:240];
  logic          a_hist [0:240];
  logic [7:0]    d_hist [0:240];
  logic          b_hist [0:240];
  int            fall_t [0:7];
  logic [NC-1:0] fall_m [0:7];

  initial begin
    int nfall, lows, bz;
    logic [NC-1:0] prev, fm;
    int exp_t[6];
    logic [NC-1:0] exp_m[6];
    exp_t = '{2, 34, 237, 269, 472, 504};
    exp_m = '{3'b010, 3'b010, 3'b001, 3'b001, 3'b010, 3'b010};

    rst_n = 0; push = 0; flush = 0; enable = 1;
    push_chip = 0; push_reg = 0; push_val = 0;
    repeat (3) @(negedge phi2);
    rst_n = 1;
    check("rst_wr_n", 32'(h_wr_n), 32'h7);
    check("rst_a0", 32'(h_a0), 32'h0);
    check("rst_din", 32'(h_din), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);

    // Single write: chip 0, reg 0x20, val 0x01; c counts negedges after the push edge.
    for (int c = 0; c <= 240; c++) begin
      push = (c == 0); push_chip = 0; push_reg = 8'h20; push_val = 8'h01;
      @(negedge phi2);
      w_hist[c] = h_wr_n; a_hist[c] = h_a0; d_hist[c] = h_din; b_hist[c] = busy;
    end
    push = 0;
    check("t1_addr_pulse", 32'({w_hist[1][0], w_hist[2][0], w_hist[3][0], w_hist[4][0]}), 32'b1001);
    check("t1_addr_setup_a0", 32'(a_hist[1]), 32'h0);
    check("t1_addr_setup_din", 32'(d_hist[1]), 32'h20);
    check("t1_addr_hold_din", 32'(d_hist[4]), 32'h20);
    lows = 0;
    for (int c = 4; c <= 33; c++) if (!w_hist[c][0]) lows++;
    check("t1_addr_gap_lows", 32'(lows), 32'h0);
    check("t1_data_pulse", 32'({w_hist[33][0], w_hist[34][0], w_hist[35][0], w_hist[36][0]}), 32'b1001);
    check("t1_data_setup_a0", 32'(a_hist[33]), 32'h1);
    check("t1_data_setup_din", 32'(d_hist[33]), 32'h01);
    bz = -1;
    for (int c = 240; c >= 0; c--) if (b_hist[c]) begin bz = c + 1; break; end
    check("t1_busy_fall", 32'(bz), 32'd235);
    lows = 0;
    for (int c = 0; c <= 240; c++) if (w_hist[c][2:1] != 2'b11) lows++;
    check("t1_other_chips_high", 32'(lows), 32'h0);

    // Three back-to-back writes to chips 1, 0, 1.
    nfall = 0; prev = h_wr_n;
    for (int c = 0; c < 720; c++) begin
      push = (c < 3); push_chip = (c == 1) ? 2'd0 : 2'd1;
      push_reg = 8'(8'hA0 + c); push_val = 8'(8'h50 + c);
      @(negedge phi2);
      fm = prev & ~h_wr_n;
      if (fm != '0 && nfall < 8) begin fall_t[nfall] = c; fall_m[nfall] = fm; nfall++; end
      prev = h_wr_n;
    end
    push = 0;
    check("t2_fall_count", 32'(nfall), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("t2_fall_time", 32'(fall_t[i]), 32'(exp_t[i]));
      check("t2_fall_chip", 32'(fall_m[i]), 32'(exp_m[i]));
    end
    wait_idle(300);

    // Overflow with enable low, then ordered replay of the first DEPTH entries.
    enable = 0;
    for (int i = 0; i < 6; i++)
      do_push(2'($urandom_range(0, 2)), 8'($urandom), 8'($urandom));
    check("t3_level_sat", 32'(level), 32'd4);
    check("t3_overflow", 32'(overflow), 32'h1);
    check("t3_busy_stalled", 32'(busy), 32'h1);
    enable = 1;
    wait_idle(5 * TOTAL);

    // Flush during the data strobe together with a push.
    do_push(2'd2, 8'hB0, 8'h33);
    wait_low(2, 100, "t4_first_strobe");
    wait_low(2, 60, "t4_data_strobe");
    while (!h_a0) @(negedge phi2);
    flush = 1; push = 1; push_chip = 0; push_reg = 8'h11; push_val = 8'h22;
    @(negedge phi2);
    flush = 0; push = 0;
    check("t4_flush_wr_n", 32'(h_wr_n), 32'h7);
    check("t4_flush_level", 32'(level), 32'h0);
    check("t4_flush_overflow", 32'(overflow), 32'h0);
    check("t4_flush_busy", 32'(busy), 32'h0);
    lows = 0;
    for (int c = 0; c < 300; c++) begin @(negedge phi2); if (h_wr_n != 3'b111) lows++; end
    check("t4_no_strobes", 32'(lows), 32'h0);

    // Enable dropped mid-write: current write completes, the next one waits.
    do_push(2'd0, 8'h40, 8'h3F);
    do_push(2'd1, 8'h41, 8'h2E);
    wait_low(0, 20, "t5_first_strobe");
    enable = 0;
    lows = 0;
    for (int c = 0; c < 400; c++) begin @(negedge phi2); if (!h_wr_n[1]) lows++; end
    check("t5_no_next_start", 32'(lows), 32'h0);
    check("t5_level_held", 32'(level), 32'h1);
    check("t5_busy_held", 32'(busy), 32'h1);
    enable = 1;
    wait_idle(3 * TOTAL);

    // Random traffic: pointer wrap, overflow, enable toggles, rare flush, invalid chip index.
    for (int c = 0; c < 9000; c++) begin
      push = ($urandom_range(0, 59) == 0);
      push_chip = 2'($urandom_range(0, 3));
      push_reg = 8'($urandom); push_val = 8'($urandom);
      enable = ($urandom_range(0, 99) < 97);
      flush = ($urandom_range(0, 2999) == 0);
      @(negedge phi2);
      check("rand_level_bound", 32'(level <= 3'd4), 32'h1);
    end
    push = 0; flush = 0; enable = 1;
    wait_idle(6 * TOTAL);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
